// File: rtl/sqrt_mag_avg_if.sv
// rtl/sqrt_mag_avg_if.sv - sample pair valid/ready bus into the magnitude averager
interface sqrt_mag_avg_if #(
  parameter int MAX_SQRT_WIDTH = 13
) ();
  logic                      SMP_VALID;
  logic                      SMP_READY;
  logic [MAX_SQRT_WIDTH-1:0] SMP_X;
  logic [MAX_SQRT_WIDTH-1:0] SMP_Y;

  modport master (output SMP_VALID, SMP_X, SMP_Y, input SMP_READY);
  modport slave  (input SMP_VALID, SMP_X, SMP_Y, output SMP_READY);
endinterface

// File: rtl/sqrt_mag_avg.sv
// rtl/sqrt_mag_avg.sv - sequences sample pairs through the CORDIC sqrt stage and averages 2^AVG_LOG2 magnitudes
module sqrt_mag_avg #(
  parameter int MAX_SQRT_WIDTH = 13,
  parameter int AVG_LOG2       = 3,
  parameter int TIMEOUT_CYC    = 255
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  sqrt_mag_avg_if.slave             smp,
  output logic                      CRD_EN,
  output logic [MAX_SQRT_WIDTH-1:0] CRD_X,
  output logic [MAX_SQRT_WIDTH-1:0] CRD_Y,
  input  logic [MAX_SQRT_WIDTH-1:0] CRD_FOUT,
  input  logic [MAX_SQRT_WIDTH-1:0] CRD_POUT,
  input  logic                      CRD_DONE,
  output logic [MAX_SQRT_WIDTH-1:0] MAG_AVG,
  output logic [MAX_SQRT_WIDTH-1:0] PHASE_LAST,
  output logic                      RESULT_VALID,
  output logic                      BUSY,
  output logic                      ERR_TIMEOUT
);
  localparam int                  ACC_W    = MAX_SQRT_WIDTH + AVG_LOG2;
  localparam logic [7:0]          TMO_LAST = 8'(TIMEOUT_CYC - 1);
  localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;

  typedef enum logic [2:0] {IDLE, WAIT_SMP, RUN, ACC, FIN} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ACC_W-1:0]    acc;
  logic [AVG_LOG2-1:0] cnt;
  logic [7:0]          tmo;
  logic                run_start;
  logic                smp_take;
  logic                crd_hit;
  logic                tmo_hit;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Done wins over timeout when both land on the same cycle.
  always_comb begin
    state_nxt     = state;
    smp.SMP_READY = 1'b0;
    BUSY          = 1'b1;
    run_start     = 1'b0;
    smp_take      = 1'b0;
    crd_hit       = 1'b0;
    tmo_hit       = 1'b0;
    unique case (state)
      IDLE: begin
        BUSY = 1'b0;
        if (START) begin
          run_start = 1'b1;
          state_nxt = WAIT_SMP;
        end
      end
      WAIT_SMP: begin
        smp.SMP_READY = 1'b1;
        if (smp.SMP_VALID) begin
          smp_take  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (CRD_DONE) begin
          crd_hit   = 1'b1;
          state_nxt = ACC;
        end else if (tmo == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      ACC:     state_nxt = (cnt == CNT_LAST) ? FIN : WAIT_SMP;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc          <= '0;
      cnt          <= '0;
      tmo          <= '0;
      CRD_EN       <= 1'b0;
      CRD_X        <= '0;
      CRD_Y        <= '0;
      MAG_AVG      <= '0;
      PHASE_LAST   <= '0;
      RESULT_VALID <= 1'b0;
      ERR_TIMEOUT  <= 1'b0;
    end else begin
      if (run_start) begin
        acc          <= '0;
        cnt          <= '0;
        tmo          <= '0;
        RESULT_VALID <= 1'b0;
        ERR_TIMEOUT  <= 1'b0;
      end
      if (smp_take) begin
        CRD_X  <= smp.SMP_X;
        CRD_Y  <= smp.SMP_Y;
        CRD_EN <= 1'b1;
        tmo    <= '0;
      end
      if (state == RUN) tmo <= tmo + 8'd1;
      // Dropping CRD_EN is what clears the CORDIC stage for the next operand.
      if (crd_hit) begin
        acc        <= acc + {{AVG_LOG2{1'b0}}, CRD_FOUT};
        PHASE_LAST <= CRD_POUT;
        CRD_EN     <= 1'b0;
      end
      if (tmo_hit) begin
        CRD_EN      <= 1'b0;
        ERR_TIMEOUT <= 1'b1;
      end
      if (state == ACC) cnt <= cnt + 1'b1;
      if (state == FIN) begin
        MAG_AVG      <= acc[ACC_W-1:AVG_LOG2];
        RESULT_VALID <= 1'b1;
      end
    end
  end
endmodule
